// File: rtl/dds_phase_tracker.sv
// dds_phase_tracker: keeps the DDS phase continuous across profile updates.
// Each accepted update folds (t_new - A) * B mod 2^48 into the accumulated
// phase E, then commits A, B, C and E together. The fold is computed with one
// 16x16 partial product per cycle (IDLE -> SUB -> MUL x6 -> COMMIT).
// Optional build macro: DDS_PHASE_TIME_GUARD_EN rejects updates whose
// timestamp lies in the past (signed delta), pulsing err instead of committing.
module dds_phase_tracker #(
  parameter int PHASE_W = 14
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [47:0]        cmd_time,
  input  logic [47:0]        cmd_freq,
  input  logic [PHASE_W-1:0] cmd_phase,
  input  logic               cmd_clr,
  output logic [47:0]        offset_time,
  output logic [47:0]        freq,
  output logic [PHASE_W-1:0] phase,
  output logic [47:0]        accum_phase,
  output logic               upd_valid,
  output logic               err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SUB    = 2'd1,
    MUL    = 2'd2,
    COMMIT = 2'd3
  } state_t;

  state_t state_q, state_d;

  // captured command
  logic [47:0]        ctime_q, ctime_d;
  logic [47:0]        cfreq_q, cfreq_d;
  logic [PHASE_W-1:0] cphase_q, cphase_d;
  logic               cclr_q, cclr_d;

  // multiply datapath
  logic [47:0] delta_q, delta_d;
  logic [47:0] prod_q, prod_d;
  logic [2:0]  cnt_q, cnt_d;

  // committed (downstream-visible) state
  logic [47:0]        off_q, off_d;
  logic [47:0]        freq_q, freq_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [47:0]        acc_q, acc_d;
  logic               upd_q, upd_d;
  logic               err_q, err_d;

  logic [47:0] delta_w;
  logic [15:0] mul_a, mul_b;
  logic [1:0]  mul_sh;
  logic [31:0] pp;
  logic [47:0] term;

  assign delta_w = ctime_q - off_q;

  // Operand/shift select for the current partial product. Only products
  // whose shift is below 48 are issued; the rest cannot reach the result.
  always_comb begin
    mul_a  = delta_q[15:0];
    mul_b  = freq_q[15:0];
    mul_sh = 2'd0;
    case (cnt_q)
      3'd0: begin mul_a = delta_q[15:0];  mul_b = freq_q[15:0];  mul_sh = 2'd0; end
      3'd1: begin mul_a = delta_q[31:16]; mul_b = freq_q[15:0];  mul_sh = 2'd1; end
      3'd2: begin mul_a = delta_q[15:0];  mul_b = freq_q[31:16]; mul_sh = 2'd1; end
      3'd3: begin mul_a = delta_q[31:16]; mul_b = freq_q[31:16]; mul_sh = 2'd2; end
      3'd4: begin mul_a = delta_q[47:32]; mul_b = freq_q[15:0];  mul_sh = 2'd2; end
      3'd5: begin mul_a = delta_q[15:0];  mul_b = freq_q[47:32]; mul_sh = 2'd2; end
      default: ;
    endcase
  end

  assign pp = {16'd0, mul_a} * {16'd0, mul_b};

  // Place the partial product at its limb position, truncated to 48 bits.
  always_comb begin
    term = {16'd0, pp};
    case (mul_sh)
      2'd1:    term = {pp, 16'd0};
      2'd2:    term = {pp[15:0], 32'd0};
      default: term = {16'd0, pp};
    endcase
  end

  // Next-state and register updates for the FSM and datapath.
  always_comb begin
    state_d  = state_q;
    ctime_d  = ctime_q;
    cfreq_d  = cfreq_q;
    cphase_d = cphase_q;
    cclr_d   = cclr_q;
    delta_d  = delta_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    off_d    = off_q;
    freq_d   = freq_q;
    phase_d  = phase_q;
    acc_d    = acc_q;
    upd_d    = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          ctime_d  = cmd_time;
          cfreq_d  = cmd_freq;
          cphase_d = cmd_phase;
          cclr_d   = cmd_clr;
          state_d  = SUB;
        end
      end
      SUB: begin
        delta_d = delta_w;
        prod_d  = '0;
        cnt_d   = 3'd0;
        state_d = MUL;
`ifdef DDS_PHASE_TIME_GUARD_EN
        // new timestamp behind the committed one: drop the update
        if (delta_w[47]) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
`endif
      end
      MUL: begin
        prod_d = prod_q + term;
        cnt_d  = cnt_q + 3'd1;
        if (cnt_q == 3'd5) state_d = COMMIT;
      end
      COMMIT: begin
        acc_d   = cclr_q ? 48'd0 : acc_q + prod_q;
        off_d   = ctime_q;
        freq_d  = cfreq_q;
        phase_d = cphase_q;
        upd_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; synchronous active-low reset aborts any command in flight.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= IDLE;
      ctime_q  <= '0;
      cfreq_q  <= '0;
      cphase_q <= '0;
      cclr_q   <= 1'b0;
      delta_q  <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      off_q    <= '0;
      freq_q   <= '0;
      phase_q  <= '0;
      acc_q    <= '0;
      upd_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctime_q  <= ctime_d;
      cfreq_q  <= cfreq_d;
      cphase_q <= cphase_d;
      cclr_q   <= cclr_d;
      delta_q  <= delta_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      off_q    <= off_d;
      freq_q   <= freq_d;
      phase_q  <= phase_d;
      acc_q    <= acc_d;
      upd_q    <= upd_d;
      err_q    <= err_d;
    end
  end

  assign cmd_ready   = (state_q == IDLE);
  assign offset_time = off_q;
  assign freq        = freq_q;
  assign phase       = phase_q;
  assign accum_phase = acc_q;
  assign upd_valid   = upd_q;
  assign err         = err_q;

endmodule

// File: tb/tb_dds_phase_tracker.sv
// tb_dds_phase_tracker: directed vectors with hand-computed expectations.
module tb_dds_phase_tracker;
  localparam int PW = 14;

  logic          clk;
  logic          resetn;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [47:0]   cmd_time;
  logic [47:0]   cmd_freq;
  logic [PW-1:0] cmd_phase;
  logic          cmd_clr;
  logic [47:0]   offset_time;
  logic [47:0]   freq;
  logic [PW-1:0] phase;
  logic [47:0]   accum_phase;
  logic          upd_valid;
  logic          err;

  int checks = 0;
  int errors = 0;

  // expected committed state before the command in flight
  logic [47:0]   e_off, e_freq, e_acc;
  logic [PW-1:0] e_phase;

  dds_phase_tracker #(.PHASE_W(PW)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_time    (cmd_time),
    .cmd_freq    (cmd_freq),
    .cmd_phase   (cmd_phase),
    .cmd_clr     (cmd_clr),
    .offset_time (offset_time),
    .freq        (freq),
    .phase       (phase),
    .accum_phase (accum_phase),
    .upd_valid   (upd_valid),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one command and check the full 9-cycle commit timeline.
  task automatic send(input logic [47:0] t, input logic [47:0] f,
                      input logic [PW-1:0] p, input logic c,
                      input logic [47:0] exp_acc, input logic noise);
    int n = 0;
    while (!cmd_ready && n < 50) begin step(); n++; end
    chk("ready_wait", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1; cmd_time = t; cmd_freq = f; cmd_phase = p; cmd_clr = c;
    step();                                    // cycle 1
    if (noise) begin
      // still valid but block is busy: must be ignored, fields not recaptured
      cmd_time = ~t; cmd_freq = ~f; cmd_phase = ~p; cmd_clr = ~c;
    end else begin
      cmd_valid = 1'b0;
    end
    chk("ready_busy", 64'(cmd_ready), 64'd0);
    for (int k = 2; k <= 8; k++) begin
      step();
      if (k == 8) begin
        cmd_valid = 1'b0;
        chk("upd_early", 64'(upd_valid), 64'd0);
        chk("off_hold", 64'(offset_time), 64'(e_off));
        chk("acc_hold", 64'(accum_phase), 64'(e_acc));
      end
    end
    step();                                    // cycle 9
    chk("upd_pulse", 64'(upd_valid), 64'd1);
    chk("ready_back", 64'(cmd_ready), 64'd1);
    chk("err_quiet", 64'(err), 64'd0);
    chk("offset", 64'(offset_time), 64'(t));
    chk("freq", 64'(freq), 64'(f));
    chk("phase", 64'(phase), 64'(p));
    chk("accum", 64'(accum_phase), 64'(exp_acc));
    e_off = t; e_freq = f; e_phase = p; e_acc = exp_acc;
    step();
    chk("upd_drop", 64'(upd_valid), 64'd0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_off"}, 64'(offset_time), 64'd0);
    chk({tag, "_freq"}, 64'(freq), 64'd0);
    chk({tag, "_phase"}, 64'(phase), 64'd0);
    chk({tag, "_acc"}, 64'(accum_phase), 64'd0);
    chk({tag, "_upd"}, 64'(upd_valid), 64'd0);
    chk({tag, "_err"}, 64'(err), 64'd0);
    chk({tag, "_ready"}, 64'(cmd_ready), 64'd1);
  endtask

  initial begin
    logic saw_upd;
    resetn = 1'b0; cmd_valid = 1'b0; cmd_time = '0; cmd_freq = '0;
    cmd_phase = '0; cmd_clr = 1'b0;
    e_off = '0; e_freq = '0; e_phase = '0; e_acc = '0;
    step(); step();
    chk_reset_state("rst");
    resetn = 1'b1;
    step();

    // first command: old freq is 0, nothing accrues; busy-time noise ignored
    send(48'd100, 48'h10, 14'd5, 1'b0, 48'd0, 1'b1);
    // 100 * 0x10 = 0x640
    send(48'd200, 48'h20, 14'd7, 1'b0, 48'h640, 1'b0);
    // clear while loading max freq
    send(48'd300, 48'hFFFF_FFFF_FFFF, 14'd0, 1'b1, 48'd0, 1'b0);
    // 2 * (2^48-1) mod 2^48: carries through every limb
    send(48'd302, 48'h1234, 14'd3, 1'b0, 48'hFFFF_FFFF_FFFE, 1'b0);
    // clear from a nonzero accumulator
    send(48'd500, 48'd3, 14'd9, 1'b1, 48'd0, 1'b0);
    // 10 * 3
    send(48'd510, 48'd7, 14'd2, 1'b0, 48'h1E, 1'b0);
    // clear with cmd_time == offset_time
    send(48'd510, 48'h0003_0002_0001, 14'd4, 1'b1, 48'd0, 1'b0);
    // delta limbs (1,1,1) x freq limbs (1,2,3): coefficients 1, 3, 6
    send(48'h0001_0001_01FF, 48'd1, 14'h3FFF, 1'b0, 48'h0006_0003_0001, 1'b0);

    // reset during the 4th MUL cycle (cycle 5 after acceptance)
    cmd_valid = 1'b1; cmd_time = 48'h0002_0000_0000; cmd_freq = 48'd5;
    cmd_phase = 14'd1; cmd_clr = 1'b0;
    step();
    cmd_valid = 1'b0;
    step(); step(); step(); step();            // cycle 5
    resetn = 1'b0;
    step();
    chk_reset_state("midrst");
    resetn = 1'b1;
    saw_upd = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (upd_valid || err) saw_upd = 1'b1;
    end
    chk("abort_quiet", 64'(saw_upd), 64'd0);
    e_off = '0; e_freq = '0; e_phase = '0; e_acc = '0;
    send(48'd100, 48'h10, 14'd5, 1'b0, 48'd0, 1'b0);
    send(48'd1000, 48'h10, 14'h3FFF, 1'b1, 48'd0, 1'b0);

    // timestamp behind offset_time: 10 - 1000
`ifdef DDS_PHASE_TIME_GUARD_EN
    cmd_valid = 1'b1; cmd_time = 48'd10; cmd_freq = 48'h22;
    cmd_phase = 14'd0; cmd_clr = 1'b0;
    step();                                    // cycle 1
    cmd_valid = 1'b0;
    chk("g_err_c1", 64'(err), 64'd0);
    step();                                    // cycle 2
    chk("g_err", 64'(err), 64'd1);
    chk("g_ready", 64'(cmd_ready), 64'd1);
    chk("g_off", 64'(offset_time), 64'd1000);
    chk("g_freq", 64'(freq), 64'h10);
    chk("g_acc", 64'(accum_phase), 64'd0);
    step();
    chk("g_err_drop", 64'(err), 64'd0);
    saw_upd = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (upd_valid) saw_upd = 1'b1;
    end
    chk("g_no_upd", 64'(saw_upd), 64'd0);
`else
    // (2^48 - 990) * 0x10 mod 2^48 = 2^48 - 0x3DE0
    send(48'd10, 48'h22, 14'd0, 1'b0, 48'hFFFF_FFFF_C220, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // hard time bound so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end

endmodule

// File: doc/dds_phase_tracker.md
# dds_phase_tracker

Phase-continuity controller that sits upstream of the DAC controller's phase MAC, which computes E + (D − A)·B + (C<<2). It accepts timed frequency/phase profile updates over a valid/ready handshake. On each update it folds the phase accrued under the outgoing profile, (t_new − A)·B mod 2^48, into the accumulated phase E, then commits the new A (time offset), B (frequency), C (phase) and E together, so the output waveform stays phase-continuous across frequency changes. The multiply is iterative: one 16×16 partial product per cycle.

## Interface
- PHASE_W, default 14: width of the absolute phase-offset field.
- clk  in  1  clock.
- resetn  in  1  reset; synchronous, active-low.
- cmd_valid  in  1  update request.
- cmd_ready  out  1  block can accept an update; high only in IDLE.
- cmd_time  in  48  timestamp at which the new profile takes effect.
- cmd_freq  in  48  new frequency tuning word.
- cmd_phase  in  PHASE_W  new absolute phase offset.
- cmd_clr  in  1  zero the accumulated phase instead of accumulating it.
- offset_time  out  48  committed A.
- freq  out  48  committed B.
- phase  out  PHASE_W  committed C.
- accum_phase  out  48  committed E.
- upd_valid  out  1  one-cycle pulse: a new profile was committed.
- err  out  1  one-cycle pulse: an update was rejected. Tied 0 unless the guard is compiled in.

## Operation
- Reset values: offset_time, freq, phase, accum_phase = 0; upd_valid = 0; err = 0; cmd_ready = 1; state IDLE.
- Handshake: a command is accepted on a clock edge where cmd_valid && cmd_ready. All cmd_* fields are captured into internal registers at that edge. cmd_ready drops the following cycle.
- FSM states: IDLE → SUB → MUL (6 cycles) → COMMIT → IDLE. The FSM leaves IDLE only on acceptance.
- SUB:
  - delta = cmd_time − offset_time, modulo 2^48.
  - Split delta into limbs d0, d1, d2 and freq into limbs f0, f1, f2 (16 bits each, d0/f0 least significant).
  - Clear the 48-bit product accumulator.
- MUL: add one partial product per cycle, in this order:
  1. d0·f0
  2. (d1·f0)<<16
  3. (d0·f1)<<16
  4. (d1·f1)<<32
  5. (d2·f0)<<32
  6. (d0·f2)<<32
  - Every term and every sum is truncated to 48 bits.
  - Higher-order products are omitted because they only affect bits ≥ 48.
- COMMIT, all outputs updated on the same edge:
  - accum_phase ← cmd_clr ? 0 : accum_phase + product (mod 2^48).
  - offset_time ← cmd_time; freq ← cmd_freq; phase ← cmd_phase.
- The committed registers are the only state visible downstream. The outputs never change other than in COMMIT or on reset.
- The multiply always uses the old freq and old offset_time, i.e. the values committed before this command.

## Timing
- Acceptance edge E0. Cycle timeline after E0: SUB in cycle 1, MUL in cycles 2–7, COMMIT in cycle 8.
- New outputs and upd_valid = 1 are visible in cycle 9, which is 9 cycles after E0. cmd_ready is also high in cycle 9.
- Throughput: one command per 9 cycles.
  - A command held valid through cycle 9 is accepted at the end of cycle 9.
  - cmd_valid while cmd_ready = 0 is ignored; it is not queued.
- Wrap-around: cmd_time < offset_time (unsigned) yields delta mod 2^48. With the guard off, the result is accumulated unchanged.
- First command after reset: freq = 0, so the product is 0 and accum_phase stays 0.
- Reset mid-operation: resetn low in any state aborts the command.
  - The FSM returns to IDLE and all outputs take their reset values on that edge.
  - No upd_valid or err pulse is emitted for the aborted command.
- cmd_clr with cmd_time equal to offset_time: accum_phase = 0. No special case is required.

## Configuration
- DDS_PHASE_TIME_GUARD_EN defined:
  - In SUB, if delta[47] = 1 (new time is in the past by the signed interpretation), skip MUL and COMMIT.
  - err pulses in cycle 2 and cmd_ready is high in cycle 2.
  - All committed outputs are unchanged and there is no upd_valid pulse.
- DDS_PHASE_TIME_GUARD_EN undefined: no check. err is held 0. delta is treated as unsigned mod 2^48.

## Test plan
- Reset, then cmd(time=100, freq=0x10, phase=5) → cycle 9: offset_time=100, freq=0x10, phase=5, accum_phase=0, upd_valid one-cycle pulse.
- Then cmd(time=200, freq=0x20) → accum_phase=0x640, offset_time=200, freq=0x20.
- freq=0xFFFF_FFFF_FFFF committed at time 0, then cmd(time=2) → accum_phase=0xFFFF_FFFF_FFFE. This checks truncation and the carry across all limbs.
- After a nonzero accum_phase, cmd(cmd_clr=1, time=500) → accum_phase=0, offset_time=500.
- Reset asserted in MUL cycle 4 → all outputs 0 next cycle, no upd_valid; a fresh command afterwards completes in 9 cycles.
- Guard: offset_time=1000, cmd(time=10).
  - With DDS_PHASE_TIME_GUARD_EN: err pulse in cycle 2, outputs unchanged.
  - Without it: accum_phase += (2^48 − 990)·freq mod 2^48.
